// File: rtl/power_to_db_mc_if.sv
// Sample/result bus of the multi-channel power-to-dB converter.
// The slave modport is the converter side; master is the producer/consumer side.
interface power_to_db_mc_if #(
  parameter int IN_W  = 32,
  parameter int NCH   = 4,
  parameter int OUT_W = 16
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 valid_i;
  logic [CH_W-1:0]      ch_i;
  logic [IN_W-1:0]      power_i;
  logic                 peak_clr_i;
  logic [CH_W-1:0]      peak_ch_i;
  logic                 valid_o;
  logic [CH_W-1:0]      ch_o;
  logic [OUT_W-1:0]     dB_o;
  logic                 zero_o;
  logic [NCH*OUT_W-1:0] peak_o;

  modport slave (
    input  valid_i, ch_i, power_i, peak_clr_i, peak_ch_i,
    output valid_o, ch_o, dB_o, zero_o, peak_o
  );

  modport master (
    output valid_i, ch_i, power_i, peak_clr_i, peak_ch_i,
    input  valid_o, ch_o, dB_o, zero_o, peak_o
  );
endinterface

// File: rtl/power_to_db_mc.sv
// Multi-channel, fully pipelined power-to-dB converter with per-channel peak hold.
// dB = 10*log10(x) computed as log2(x) * 10*log10(2); log2 from leading-one
// position plus a linear mantissa. Four register stages, one sample per cycle.
// Optional macro PDB_LOG_CORR_EN adds a 16-entry mantissa correction table.
module power_to_db_mc #(
  parameter int IN_W       = 32,
  parameter int NCH        = 4,
  parameter int LOG_FRAC   = 8,
  parameter int COEFF_FRAC = 20,
  parameter int OUT_W      = 16,
  parameter int OUT_FRAC   = 4
) (
  input logic               clk,
  input logic               rst_n,
  power_to_db_mc_if.slave   bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int E_W  = $clog2(IN_W);
`ifdef PDB_LOG_CORR_EN
  // one spare bit: f + corr can carry into the exponent field
  localparam int L_W  = E_W + LOG_FRAC + 1;
`else
  localparam int L_W  = E_W + LOG_FRAC;
`endif
  // 10*log10(2) < 4, so two integer bits suffice for K
  localparam int K_W  = COEFF_FRAC + 2;
  localparam int P_W  = L_W + K_W;
  localparam int S    = COEFF_FRAC + LOG_FRAC - OUT_FRAC;
  localparam int K_INT = $rtoi(3.0102999566398120 * (2.0 ** COEFF_FRAC) + 0.5);
  localparam logic [K_W-1:0] K       = K_W'(K_INT);
  localparam logic [P_W:0]   HALF    = {{P_W{1'b0}}, 1'b1} << (S - 1);
  localparam logic [P_W:0]   SAT_MAX = (P_W+1)'({OUT_W{1'b1}});

  // index of the most significant set bit (0 for x == 0)
  function automatic logic [E_W-1:0] lead_one(input logic [IN_W-1:0] x);
    logic [E_W-1:0] e;
    e = '0;
    for (int i = 0; i < IN_W; i++)
      if (x[i]) e = E_W'(i);
    return e;
  endfunction

  // top LOG_FRAC bits below the leading one, truncated
  function automatic logic [LOG_FRAC-1:0] mant_frac(input logic [IN_W-1:0] x,
                                                    input logic [E_W-1:0]  e);
    logic [IN_W-1:0] sh;
    sh = x << (E_W'(IN_W - 1) - e);
    return sh[IN_W-2 -: LOG_FRAC];
  endfunction

  // round half-up to OUT_FRAC fractional bits, then saturate to OUT_W
  function automatic logic [OUT_W-1:0] round_sat(input logic [P_W-1:0] p);
    logic [P_W:0] r;
    r = ({1'b0, p} + HALF) >> S;
    if (r > SAT_MAX) return {OUT_W{1'b1}};
    return r[OUT_W-1:0];
  endfunction

`ifdef PDB_LOG_CORR_EN
  logic [LOG_FRAC-1:0] w_corr [16];
  for (genvar j = 0; j < 16; j++) begin : g_corr
    localparam real M  = (j + 0.5) / 16.0;
    localparam int  CV = $rtoi((($ln(1.0 + M) / $ln(2.0)) - M) * (2.0 ** LOG_FRAC) + 0.5);
    assign w_corr[j] = LOG_FRAC'(CV);
  end
`endif

  logic                  r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
  logic [CH_W-1:0]       r_ch_p1, r_ch_p2, r_ch_p3, r_ch_p4;
  logic                  r_zero_p2, r_zero_p3, r_zero_p4;
  logic [IN_W-1:0]       r_pow_p1;
  logic [L_W-1:0]        r_log_p2;
  logic [P_W-1:0]        r_prod_p3;
  logic [OUT_W-1:0]      r_db_p4;
  logic [NCH-1:0][OUT_W-1:0] r_peak;

  logic [E_W-1:0]        w_e;
  logic [LOG_FRAC-1:0]   w_f;
  logic [L_W-1:0]        w_log;
  logic                  w_zero;
  logic [NCH-1:0][OUT_W-1:0] w_peak_nxt;
  logic [OUT_W-1:0]      w_cur;

  // stage 1: capture the incoming sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_ch_p1  <= '0;
      r_pow_p1 <= '0;
    end else begin
      r_vld_p1 <= bus.valid_i;
      r_ch_p1  <= bus.ch_i;
      r_pow_p1 <= bus.power_i;
    end
  end

  // stage 2 logic: log2 approximation = exponent . mantissa fraction
  always_comb begin
    w_e    = lead_one(r_pow_p1);
    w_f    = mant_frac(r_pow_p1, w_e);
    w_zero = (r_pow_p1 == '0);
`ifdef PDB_LOG_CORR_EN
    w_log  = L_W'({w_e, w_f}) + L_W'(w_corr[w_f[LOG_FRAC-1 -: 4]]);
`else
    w_log  = {w_e, w_f};
`endif
    if (w_zero) w_log = '0;
  end

  // stage 2: register log2 value and zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_ch_p2   <= '0;
      r_zero_p2 <= 1'b0;
      r_log_p2  <= '0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_ch_p2   <= r_ch_p1;
      r_zero_p2 <= w_zero;
      r_log_p2  <= w_log;
    end
  end

  // stage 3: full-precision scale by 10*log10(2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p3  <= 1'b0;
      r_ch_p3   <= '0;
      r_zero_p3 <= 1'b0;
      r_prod_p3 <= '0;
    end else begin
      r_vld_p3  <= r_vld_p2;
      r_ch_p3   <= r_ch_p2;
      r_zero_p3 <= r_zero_p2;
      r_prod_p3 <= P_W'(r_log_p2) * P_W'(K);
    end
  end

  // stage 4: round/saturate; outputs hold their value across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p4  <= 1'b0;
      r_ch_p4   <= '0;
      r_zero_p4 <= 1'b0;
      r_db_p4   <= '0;
    end else begin
      r_vld_p4 <= r_vld_p3;
      if (r_vld_p3) begin
        r_ch_p4   <= r_ch_p3;
        r_zero_p4 <= r_zero_p3;
        r_db_p4   <= r_zero_p3 ? '0 : round_sat(r_prod_p3);
      end
    end
  end

  // next peak per channel: clear first, then max with the current output
  always_comb begin
    w_peak_nxt = r_peak;
    w_cur      = '0;
    for (int c = 0; c < NCH; c++) begin
      w_cur = r_peak[c];
      if (bus.peak_clr_i && (bus.peak_ch_i == CH_W'(c)))
        w_cur = '0;
      if (r_vld_p4 && (r_ch_p4 == CH_W'(c)) && (r_db_p4 > w_cur))
        w_cur = r_db_p4;
      w_peak_nxt[c] = w_cur;
    end
  end

  // peak-hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_peak <= '0;
    else        r_peak <= w_peak_nxt;
  end

  assign bus.valid_o = r_vld_p4;
  assign bus.ch_o    = r_ch_p4;
  assign bus.dB_o    = r_db_p4;
  assign bus.zero_o  = r_zero_p4;
  assign bus.peak_o  = r_peak;
endmodule

// File: tb/tb_power_to_db_mc.sv
// Directed bench for power_to_db_mc: latency, values, zero flag, peak hold,
// clear collision and output saturation (second instance with OUT_W = 10).
module tb_power_to_db_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  power_to_db_mc_if #(.IN_W(32), .NCH(4), .OUT_W(16)) if0 ();
  power_to_db_mc_if #(.IN_W(32), .NCH(4), .OUT_W(10)) if1 ();

  power_to_db_mc #(.IN_W(32), .NCH(4), .LOG_FRAC(8), .COEFF_FRAC(20),
                   .OUT_W(16), .OUT_FRAC(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(if0));
  power_to_db_mc #(.IN_W(32), .NCH(4), .LOG_FRAC(8), .COEFF_FRAC(20),
                   .OUT_W(10), .OUT_FRAC(4)) u_sat (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    if0.valid_i = 1'b0; if0.ch_i = '0; if0.power_i = '0;
    if0.peak_clr_i = 1'b0; if0.peak_ch_i = '0;
    if1.valid_i = 1'b0; if1.ch_i = '0; if1.power_i = '0;
    if1.peak_clr_i = 1'b0; if1.peak_ch_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    if0.valid_i = 1'b1; if0.ch_i = 2'd0; if0.power_i = 32'd1024;
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (if0.valid_o !== 1'b1 || if0.dB_o !== 16'd482) begin
      n_err++; $display("FAIL pre_reset_out: got v=%0d dB=%0d want v=1 dB=482", if0.valid_o, if0.dB_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (if0.valid_o !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %0d want 0", if0.valid_o);
    end
    n_vec++;
    if (if0.dB_o !== 16'd0) begin
      n_err++; $display("FAIL rst_db: got %0d want 0", if0.dB_o);
    end
    n_vec++;
    if (if0.peak_o !== 64'd0) begin
      n_err++; $display("FAIL rst_peak: got %0h want 0", if0.peak_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) if0.valid_i = 1'b0;
      n_vec++;
      if (if0.valid_o !== ((k == 4) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL rst_latency_k%0d: got %0d want %0d", k, if0.valid_o, (k == 4));
      end
    end
    n_vec++;
    if (if0.dB_o !== 16'd482) begin
      n_err++; $display("FAIL rst_first_db: got %0d want 482", if0.dB_o);
    end
  endtask

  task automatic test_single();
    logic [31:0] xs [4] = '{32'd1, 32'd1024, 32'd3, 32'h8000_0000};
    logic [15:0] es [4] = '{16'd0, 16'd482, 16'd72, 16'd1493};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if0.valid_i = 1'b1; if0.ch_i = 2'd0; if0.power_i = xs[i];
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) if0.valid_i = 1'b0;
        if (k == 3) begin
          n_vec++;
          if (if0.valid_o !== 1'b0) begin
            n_err++; $display("FAIL single%0d_early: got valid %0d want 0", i, if0.valid_o);
          end
        end
      end
      n_vec++;
      if (if0.valid_o !== 1'b1) begin
        n_err++; $display("FAIL single%0d_valid: got %0d want 1", i, if0.valid_o);
      end
      n_vec++;
      if (if0.dB_o !== es[i]) begin
        n_err++; $display("FAIL single%0d_db: got %0d want %0d", i, if0.dB_o, es[i]);
      end
      n_vec++;
      if (if0.zero_o !== 1'b0 || if0.ch_o !== 2'd0) begin
        n_err++; $display("FAIL single%0d_flags: got zero=%0d ch=%0d want 0 0", i, if0.zero_o, if0.ch_o);
      end
    end
  endtask

  task automatic test_zero();
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin if0.valid_i = 1'b1; if0.ch_i = 2'd2; if0.power_i = 32'd3; end
      if (k == 1) if0.valid_i = 1'b0;
    end
    n_vec++;
    if (if0.peak_o[2*16 +: 16] !== 16'd72) begin
      n_err++; $display("FAIL zero_prepeak: got %0d want 72", if0.peak_o[2*16 +: 16]);
    end
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin if0.valid_i = 1'b1; if0.ch_i = 2'd2; if0.power_i = 32'd0; end
      if (k == 1) if0.valid_i = 1'b0;
      if (k == 4) begin
        n_vec++;
        if (if0.valid_o !== 1'b1 || if0.dB_o !== 16'd0 || if0.zero_o !== 1'b1 || if0.ch_o !== 2'd2) begin
          n_err++; $display("FAIL zero_out: got v=%0d dB=%0d z=%0d ch=%0d want 1 0 1 2",
                            if0.valid_o, if0.dB_o, if0.zero_o, if0.ch_o);
        end
      end
    end
    n_vec++;
    if (if0.peak_o[2*16 +: 16] !== 16'd72) begin
      n_err++; $display("FAIL zero_peak: got %0d want 72", if0.peak_o[2*16 +: 16]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [4] = '{32'd1024, 32'd3, 32'h8000_0000, 32'd1};
    logic [15:0] es [4] = '{16'd482, 16'd72, 16'd1493, 16'd0};
    logic [15:0] pk;
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 4 && k <= 7) begin
        n_vec++;
        if (if0.valid_o !== 1'b1 || if0.ch_o !== 2'(k - 4) || if0.dB_o !== es[k-4]) begin
          n_err++; $display("FAIL b2b_out%0d: got v=%0d ch=%0d dB=%0d want 1 %0d %0d",
                            k - 4, if0.valid_o, if0.ch_o, if0.dB_o, k - 4, es[k-4]);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (if0.valid_o !== 1'b0) begin
          n_err++; $display("FAIL b2b_bubble: got %0d want 0", if0.valid_o);
        end
      end
      if (k < 4) begin
        if0.valid_i = 1'b1; if0.ch_i = 2'(k); if0.power_i = xs[k];
      end else begin
        if0.valid_i = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      pk = if0.peak_o[c*16 +: 16];
      n_vec++;
      if (pk !== es[c]) begin
        n_err++; $display("FAIL b2b_peak%0d: got %0d want %0d", c, pk, es[c]);
      end
    end
  endtask

  task automatic test_peak_clear();
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin if0.valid_i = 1'b1; if0.ch_i = 2'd1; if0.power_i = 32'h8000_0000; end
      if (k == 1) if0.valid_i = 1'b0;
    end
    n_vec++;
    if (if0.peak_o[1*16 +: 16] !== 16'd1493) begin
      n_err++; $display("FAIL clr_setup: got %0d want 1493", if0.peak_o[1*16 +: 16]);
    end
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin if0.valid_i = 1'b1; if0.ch_i = 2'd1; if0.power_i = 32'd3; end
      if (k == 1) if0.valid_i = 1'b0;
      if (k == 4) begin
        n_vec++;
        if (if0.valid_o !== 1'b1 || if0.dB_o !== 16'd72 || if0.ch_o !== 2'd1) begin
          n_err++; $display("FAIL clr_out: got v=%0d dB=%0d ch=%0d want 1 72 1",
                            if0.valid_o, if0.dB_o, if0.ch_o);
        end
        if0.peak_clr_i = 1'b1; if0.peak_ch_i = 2'd1;
      end
      if (k == 5) if0.peak_clr_i = 1'b0;
    end
    n_vec++;
    if (if0.peak_o[1*16 +: 16] !== 16'd72) begin
      n_err++; $display("FAIL clr_collide: got %0d want 72", if0.peak_o[1*16 +: 16]);
    end
    if0.peak_clr_i = 1'b1; if0.peak_ch_i = 2'd1;
    @(negedge clk);
    if0.peak_clr_i = 1'b0;
    n_vec++;
    if (if0.peak_o[1*16 +: 16] !== 16'd0) begin
      n_err++; $display("FAIL clr_plain: got %0d want 0", if0.peak_o[1*16 +: 16]);
    end
    n_vec++;
    if (if0.peak_o[2*16 +: 16] !== 16'd1493 || if0.peak_o[0 +: 16] !== 16'd482) begin
      n_err++; $display("FAIL clr_others: got p0=%0d p2=%0d want 482 1493",
                        if0.peak_o[0 +: 16], if0.peak_o[2*16 +: 16]);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] xs [2] = '{32'h8000_0000, 32'd1024};
    logic [9:0]  es [2] = '{10'd1023, 10'd482};
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k <= 4; k++) begin
        @(negedge clk);
        if (k == 0) begin if1.valid_i = 1'b1; if1.ch_i = 2'd0; if1.power_i = xs[i]; end
        if (k == 1) if1.valid_i = 1'b0;
      end
      n_vec++;
      if (if1.valid_o !== 1'b1 || if1.dB_o !== es[i]) begin
        n_err++; $display("FAIL sat%0d_db: got v=%0d dB=%0d want 1 %0d", i, if1.valid_o, if1.dB_o, es[i]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (if1.peak_o[0 +: 10] !== 10'd1023) begin
      n_err++; $display("FAIL sat_peak: got %0d want 1023", if1.peak_o[0 +: 10]);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_peak_clear();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
